// File: rtl/bf16_board_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// bf16_board_pkg: shared types and constants for the bf16 FMA board.
// Rev 1.0
// ------------------------------------------------------------------
package bf16_board_pkg;

  localparam int BF16_W = 16;
  localparam logic [BF16_W-1:0] ERR_WORD = 16'hEEEE;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_C    = 3'd2,
    S_RUN  = 3'd3,
    S_SHOW = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam logic [3:0] LED_A    = 4'b0001;
  localparam logic [3:0] LED_B    = 4'b0010;
  localparam logic [3:0] LED_C    = 4'b0100;
  localparam logic [3:0] LED_RUN  = 4'b0000;
  localparam logic [3:0] LED_SHOW = 4'b1000;
  localparam logic [3:0] LED_ERR  = 4'b1111;

  function automatic logic [3:0] stage_code(input state_e s);
    case (s)
      S_A:     return LED_A;
      S_B:     return LED_B;
      S_C:     return LED_C;
      S_RUN:   return LED_RUN;
      S_SHOW:  return LED_SHOW;
      S_ERR:   return LED_ERR;
      default: return LED_RUN;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ------------------------------------------------------------------
// btn_debounce: 2-flop synchroniser, stability counter, one-cycle press.
// Rev 1.0
// ------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      // The level flips on the cycle that completes the stable run.
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        press_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_press = press_q;

endmodule
`default_nettype wire

// File: rtl/bf16_operand_entry.sv
`default_nettype none
// ------------------------------------------------------------------
// bf16_operand_entry: captures A/B/C from switches, launches one FMA, shows result.
// Rev 1.0
// ------------------------------------------------------------------
module bf16_operand_entry
  import bf16_board_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic              clock_100Mhz,
  input  logic              reset_n,
  input  logic [BF16_W-1:0] sw,
  input  logic              btn_next,
  output logic [BF16_W-1:0] op_a,
  output logic [BF16_W-1:0] op_b,
  output logic [BF16_W-1:0] op_c,
  output logic              fma_start,
  input  logic              fma_valid,
  input  logic [BF16_W-1:0] fma_result,
  output logic [BF16_W-1:0] display_word,
  output logic [3:0]        stage_led,
  output logic              busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic press;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_next (
    .clk       (clock_100Mhz),
    .rst_n     (reset_n),
    .btn_raw   (btn_next),
    .btn_press (press)
  );

  state_e            state_q, state_d;
  logic [BF16_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
  logic [BF16_W-1:0] result_q, result_d;
  logic [BF16_W-1:0] display_q, display_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              start_q, start_d;
  logic [3:0]        stage_led_q, stage_led_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_c_d   = op_c_q;
    result_d = result_q;
    tmo_d    = '0;
    start_d  = 1'b0;
    case (state_q)
      S_A: if (press) begin op_a_d = sw; state_d = S_B; end
      S_B: if (press) begin op_b_d = sw; state_d = S_C; end
      S_C: if (press) begin
        op_c_d  = sw;
        state_d = S_RUN;
        start_d = 1'b1;
      end
      S_RUN: begin
        // A valid on the expiry cycle takes priority over the timeout.
        tmo_d = tmo_q + 1'b1;
        if (fma_valid) begin
          result_d = fma_result;
          state_d  = S_SHOW;
          tmo_d    = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
          tmo_d   = '0;
        end
      end
      S_SHOW, S_ERR: if (press) state_d = S_A;
      default: state_d = S_A;
    endcase

    case (state_q)
      S_A, S_B, S_C: display_d = sw;
      S_RUN:         display_d = op_c_q;
      S_SHOW:        display_d = result_q;
      S_ERR:         display_d = ERR_WORD;
      default:       display_d = '0;
    endcase

    stage_led_d = stage_code(state_d);
    busy_d      = (state_d == S_RUN);
  end

  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_A;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_c_q      <= '0;
      result_q    <= '0;
      display_q   <= '0;
      tmo_q       <= '0;
      start_q     <= 1'b0;
      stage_led_q <= LED_A;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_c_q      <= op_c_d;
      result_q    <= result_d;
      display_q   <= display_d;
      tmo_q       <= tmo_d;
      start_q     <= start_d;
      stage_led_q <= stage_led_d;
      busy_q      <= busy_d;
    end
  end

  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign op_c         = op_c_q;
  assign fma_start    = start_q;
  assign display_word = display_q;
  assign stage_led    = stage_led_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bf16_operand_entry.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_bf16_operand_entry: directed self-checking bench for bf16_operand_entry.
// Rev 1.0
// ------------------------------------------------------------------
module tb_bf16_operand_entry;

  localparam int DEB = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sw = 16'h0000;
  logic        btn = 1'b0;
  logic        fma_valid = 1'b0;
  logic [15:0] fma_result = 16'h0000;
  logic [15:0] op_a, op_b, op_c, display_word;
  logic        fma_start, busy;
  logic [3:0]  stage_led;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_busy   = 0;

  always #5 clk = ~clk;

  bf16_operand_entry #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock_100Mhz(clk),
    .reset_n     (rst_n),
    .sw          (sw),
    .btn_next    (btn),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_c        (op_c),
    .fma_start   (fma_start),
    .fma_valid   (fma_valid),
    .fma_result  (fma_result),
    .display_word(display_word),
    .stage_led   (stage_led),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (fma_start) n_start++;
    if (busy) n_busy++;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Raw edge to press takes 6 edges, the state moves on the 7th.
  task automatic press(input int hold);
    btn = 1'b1;
    repeat (hold) tick();
    btn = 1'b0;
    repeat (8) tick();
  endtask

  // Leaves the bench in the first S_RUN cycle.
  task automatic enter_run(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    sw = a; press(10);
    sw = b; press(10);
    sw = c;
    btn = 1'b1;
    repeat (7) tick();
    btn = 1'b0;
    check("run_first_start", {15'b0, fma_start}, 16'h0001);
  endtask

  initial begin
    // Reset and release
    sw = 16'h1234;
    repeat (3) tick();
    check("rst_stage", {12'b0, stage_led}, 16'h0001);
    check("rst_display", display_word, 16'h0000);
    check("rst_op_a", op_a, 16'h0000);
    check("rst_busy_start", {14'b0, busy, fma_start}, 16'h0000);
    rst_n = 1'b1;
    check("rel_display_before", display_word, 16'h0000);
    tick();
    check("rel_display_sw", display_word, 16'h1234);

    // Bounce: short glitch, then a clean held press
    sw  = 16'h3F80;
    btn = 1'b1; repeat (2) tick();
    btn = 1'b0; repeat (10) tick();
    check("glitch_stage", {12'b0, stage_led}, 16'h0001);
    btn = 1'b1;
    repeat (6) tick();
    check("press_lat6_stage", {12'b0, stage_led}, 16'h0001);
    tick();
    check("press_lat7_stage", {12'b0, stage_led}, 16'h0002);
    repeat (93) tick();
    btn = 1'b0;
    repeat (10) tick();
    check("held_one_adv", {12'b0, stage_led}, 16'h0002);
    check("held_op_a", op_a, 16'h3F80);

    // Full flow
    sw = 16'h4000; press(10);
    check("flow_op_b", op_b, 16'h4000);
    check("flow_stage_c", {12'b0, stage_led}, 16'h0004);
    sw = 16'h3F80;
    n_start = 0; n_busy = 0;
    btn = 1'b1;
    repeat (7) tick();
    check("flow_start_c1", {15'b0, fma_start}, 16'h0001);
    check("flow_stage_run", {12'b0, stage_led}, 16'h0000);
    tick();
    check("flow_start_c2", {15'b0, fma_start}, 16'h0000);
    check("flow_disp_opc", display_word, 16'h3F80);
    tick();
    btn = 1'b0;
    tick();
    fma_valid = 1'b1; fma_result = 16'h4040;
    tick();
    fma_valid = 1'b0; fma_result = 16'h0000;
    repeat (3) tick();
    check("flow_op_a", op_a, 16'h3F80);
    check("flow_op_c", op_c, 16'h3F80);
    check("flow_display", display_word, 16'h4040);
    check("flow_stage_show", {12'b0, stage_led}, 16'h0008);
    check("flow_busy_cycles", n_busy[15:0], 16'd4);
    check("flow_start_cycles", n_start[15:0], 16'd1);

    press(10);
    check("show_to_a_stage", {12'b0, stage_led}, 16'h0001);
    check("ops_retained", op_a, 16'h3F80);

    // fma_valid ignored outside S_RUN
    sw = 16'h5A5A; fma_valid = 1'b1; fma_result = 16'hBEEF;
    repeat (3) tick();
    check("idle_valid_disp", display_word, 16'h5A5A);
    check("idle_valid_stage", {12'b0, stage_led}, 16'h0001);
    fma_valid = 1'b0; fma_result = 16'h0000;

    // Timeout
    enter_run(16'h1111, 16'h2222, 16'h3333);
    repeat (15) tick();
    check("tmo_c16_busy", {15'b0, busy}, 16'h0001);
    tick();
    check("tmo_stage_err", {12'b0, stage_led}, 16'h000F);
    check("tmo_busy_low", {15'b0, busy}, 16'h0000);
    tick();
    check("tmo_display", display_word, 16'hEEEE);
    press(10);
    check("err_to_a_stage", {12'b0, stage_led}, 16'h0001);

    // Valid on expiry cycle plus a press during S_RUN
    enter_run(16'h0A0A, 16'h0B0B, 16'h0C0C);
    repeat (8) tick();
    btn = 1'b1;
    repeat (7) tick();
    check("runpress_stage", {12'b0, stage_led}, 16'h0000);
    fma_valid = 1'b1; fma_result = 16'hABCD;
    tick();
    fma_valid = 1'b0; fma_result = 16'h0000;
    check("expiry_valid_show", {12'b0, stage_led}, 16'h0008);
    tick();
    check("expiry_display", display_word, 16'hABCD);
    check("expiry_op_c", op_c, 16'h0C0C);
    btn = 1'b0;
    repeat (10) tick();
    check("release_no_press", {12'b0, stage_led}, 16'h0008);
    press(10);

    // Reset two cycles after fma_start
    enter_run(16'h1357, 16'h2468, 16'h369C);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_stage", {12'b0, stage_led}, 16'h0001);
    check("midrst_op_a", op_a, 16'h0000);
    check("midrst_display", display_word, 16'h0000);
    check("midrst_busy_start", {14'b0, busy, fma_start}, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fma_valid = 1'b1; fma_result = 16'h7777; sw = 16'h2468;
    repeat (2) tick();
    fma_valid = 1'b0;
    check("late_valid_stage", {12'b0, stage_led}, 16'h0001);
    check("late_valid_op_c", op_c, 16'h0000);
    check("late_valid_disp", display_word, 16'h2468);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
